fifo_ptr_ctrl: RTL and testbench

//  Initiator side of the RAM_memory port: turns push/pop requests into write/read strobes plus wr_ptr/rd_ptr.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ptr_ctrl_ptr_counter.sv | 24 ++
 rtl/fifo_ptr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO pointer controller.
// Imported by the controller top and its pointer counters.
package fifo_pkg;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int AF_THR = 60;
  localparam int AE_THR = 4;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

  typedef enum logic [1:0] {
    S_INIT   = ST_INIT,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } state_t;

endpackage

// File: rtl/fifo_ptr_ctrl_ptr_counter.sv
// Wrapping address counter with increment and synchronous clear.
// Used for both the write and the read pointer of the FIFO.
module ptr_counter #(
  parameter int W = fifo_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // Natural binary overflow gives the 63 -> 0 wrap.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: push/pop to RAM strobes and addresses,
// occupancy flags, sticky overflow/underflow and read-valid stage.
module fifo_ptr_ctrl #(
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int AF_THR = fifo_pkg::AF_THR,
  parameter int AE_THR = fifo_pkg::AE_THR
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              ready,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              rd_valid,
  output logic              overflow,
  output logic              underflow
);

  import fifo_pkg::*;

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(2 ** ADDR_W);
  localparam logic [CW-1:0] AF_C = CW'(AF_THR);
  localparam logic [CW-1:0] AE_C = CW'(AE_THR);

  state_t state;
  logic   active;
  logic   ovf_ev;
  logic   unf_ev;

  assign active       = (state == S_ACTIVE);
  assign ready        = active;

  assign full         = (count == CNT_MAX);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign write  = active & push & ~full & ~flush;
  assign read   = active & pop & ~empty & ~flush;
  assign ovf_ev = active & push & full & ~flush;
  assign unf_ev = active & pop & empty & ~flush;

  ptr_counter #(.W(ADDR_W)) u_wr (
    .clk     (clk),
    .reset_L (reset_L),
    .inc     (write),
    .clr     (flush),
    .ptr     (wr_ptr)
  );

  ptr_counter #(.W(ADDR_W)) u_rd (
    .clk     (clk),
    .reset_L (reset_L),
    .inc     (read),
    .clr     (flush),
    .ptr     (rd_ptr)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= S_INIT;
    end else if (flush) begin
      state <= S_ACTIVE;
    end else begin
      unique case (state)
        S_INIT:   state <= S_ACTIVE;
        S_ACTIVE: if (ovf_ev | unf_ev) state <= S_ERROR;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_INIT;
      endcase
    end
  end

  // Accepted push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (flush) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (write & ~read) begin
        count <= count + CW'(1);
      end else if (read & ~write) begin
        count <= count - CW'(1);
      end
      if (ovf_ev) overflow <= 1'b1;
      if (unf_ev) underflow <= 1'b1;
      rd_valid <= read;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl paired with a 64x4 registered RAM.
// Stimulus queues expected read data; a monitor checks it on rd_valid.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push, pop, flush;
  logic       write, read;
  logic [5:0] wr_ptr, rd_ptr;
  logic [6:0] count;
  logic       ready, full, empty;
  logic       almost_full, almost_empty;
  logic       rd_valid, overflow, underflow;

  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] mem [64];

  logic [3:0] mdl [$];
  logic [3:0] sb  [$];
  logic [3:0] sb_exp;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fifo_ptr_ctrl dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .ready        (ready),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .rd_valid     (rd_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // RAM_memory stand-in: registered data_out.
  always @(posedge clk) begin
    if (write) mem[wr_ptr] <= din;
    if (read) dout <= mem[rd_ptr];
  end

  always @(negedge clk) begin
    if (reset_L && rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rd_valid_unexpected got=1 want=0");
      end else begin
        sb_exp = sb.pop_front();
        if (dout !== sb_exp) begin
          fails++;
          $display("FAIL rd_data got=%0d want=%0d",
                   dout, sb_exp);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    mdl.delete();
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    push = 0; pop = 0; flush = 0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_count", count, 0);
    chk("rst_strobes", {write, read, rd_valid}, 0);
    chk("rst_err", {overflow, underflow}, 0);

    // 1: one idle clock after release
    reset_L = 1'b1;
    tick();
    chk("t1_ready", ready, 1);
    chk("t1_flags", {empty, almost_empty, full}, 3'b110);
    chk("t1_count", count, 0);
    chk("t1_strobes", {write, read}, 0);

    // 2: 16 pushes then 16 pops
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      din = 4'(i);
      mdl.push_back(4'(i));
      #1;
      if (i == 0) chk("t2_write", write, 1);
      tick();
    end
    push = 1'b0;
    chk("t2_count16", count, 16);
    chk("t2_wrptr", wr_ptr, 16);
    chk("t2_ae", almost_empty, 0);
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      sb.push_back(mdl.pop_front());
      #1;
      if (i == 0) chk("t2_read", read, 1);
      tick();
      if (i == 0) chk("t2_rdvalid", rd_valid, 1);
    end
    pop = 1'b0;
    tick();
    chk("t2_rdvalid_off", rd_valid, 0);
    chk("t2_count0", count, 0);
    chk("t2_rdptr", rd_ptr, 16);
    chk("t2_sb_drained", sb.size(), 0);

    // 3: fill 64 words from pointer 0, then overflow
    do_flush();
    chk("t3_ptrs0", {wr_ptr, rd_ptr}, 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 59) chk("t3_af59", almost_full, 0);
      if (i == 60) chk("t3_af60", almost_full, 1);
      push = 1'b1;
      din = 4'(i);
      mdl.push_back(4'(i));
      tick();
    end
    chk("t3_full", full, 1);
    chk("t3_af", almost_full, 1);
    chk("t3_count64", count, 64);
    chk("t3_wrptr_wrap", wr_ptr, 0);
    #1;
    chk("t3_write65", write, 0);
    tick();
    push = 1'b0;
    chk("t3_overflow", overflow, 1);
    chk("t3_ready0", ready, 0);
    chk("t3_count_hold", count, 64);
    do_flush();
    chk("t3_flush_ready", ready, 1);
    chk("t3_flush_err", overflow, 0);
    chk("t3_flush_count", count, 0);

    // 4: pop while empty, push ignored in ERROR
    pop = 1'b1;
    #1;
    chk("t4_read0", read, 0);
    tick();
    pop = 1'b0;
    chk("t4_underflow", underflow, 1);
    chk("t4_ready0", ready, 0);
    push = 1'b1;
    din = 4'd5;
    #1;
    chk("t4_push_ign", write, 0);
    tick();
    push = 1'b0;
    chk("t4_count0", count, 0);
    chk("t4_wrptr0", wr_ptr, 0);
    do_flush();
    chk("t4_flush", {ready, underflow, empty}, 3'b101);
    chk("t4_ptrs", {wr_ptr, rd_ptr}, 0);
    // push+pop at empty: push taken, pop flagged
    push = 1'b1;
    pop = 1'b1;
    din = 4'd9;
    #1;
    chk("t4_pp_strobes", {write, read}, 2'b10);
    tick();
    push = 1'b0;
    pop = 1'b0;
    chk("t4_pp_count", count, 1);
    chk("t4_pp_unf", {underflow, ready}, 2'b10);
    do_flush();

    // 5: count=10 then 70 cycles of push+pop
    for (int i = 0; i < 10; i++) begin
      push = 1'b1;
      din = 4'((i * 3) & 15);
      mdl.push_back(4'((i * 3) & 15));
      tick();
    end
    push = 1'b0;
    chk("t5_count10", count, 10);
    for (int i = 0; i < 70; i++) begin
      push = 1'b1;
      pop = 1'b1;
      din = 4'((i + 7) & 15);
      mdl.push_back(4'((i + 7) & 15));
      sb.push_back(mdl.pop_front());
      #1;
      if (i == 0) chk("t5_both", {write, read}, 2'b11);
      tick();
    end
    push = 1'b0;
    pop = 1'b0;
    chk("t5_count_hold", count, 10);
    chk("t5_wrptr", wr_ptr, 16);
    chk("t5_rdptr", rd_ptr, 6);
    tick();
    tick();
    chk("t5_sb_drained", sb.size(), 0);

    // 6: async reset at count 30
    do_flush();
    for (int i = 0; i < 30; i++) begin
      push = 1'b1;
      din = 4'(i);
      tick();
    end
    chk("t6_count30", count, 30);
    reset_L = 1'b0;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_flags", {ready, empty, almost_empty}, 3'b011);
    chk("t6_async_strb", {write, read, rd_valid}, 0);
    chk("t6_async_ptr", wr_ptr, 0);
    mdl.delete();
    sb.delete();
    tick();
    reset_L = 1'b1;
    #1;
    chk("t6_init_write", write, 0);
    chk("t6_init_ready", ready, 0);
    tick();
    push = 1'b0;
    chk("t6_active", ready, 1);
    chk("t6_init_ign", count, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
